// File: rtl/decoder_pipe_wsel.sv
// rtl/decoder_pipe_wsel.sv - pipelined ADDR_W-to-2**ADDR_W one-hot write-enable decoder with stall/flush.
// Optional sticky one-hot checker on out, enabled by DECODE_ONEHOT_CHK_EN.
module decoder_pipe_wsel #(
  parameter int ADDR_W       = 5,
  parameter int STAGES       = 1,
  parameter int SUPPRESS_TOP = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    in,
  input  logic                 enable,
  input  logic                 stall,
  input  logic                 flush,
  output logic [2**ADDR_W-1:0] out,
  output logic                 out_valid,
  output logic [ADDR_W-1:0]    addr_q
`ifdef DECODE_ONEHOT_CHK_EN
  ,
  output logic                 err
`endif
);

  localparam int N = 2**ADDR_W;

  logic              src_valid;
  logic [ADDR_W-1:0] src_addr;
  logic              src_en;

  if (ADDR_W < 1 || ADDR_W > 6) begin : g_bad_addr_w
    $fatal(1, "decoder_pipe_wsel: ADDR_W must be 1..6");
  end

  if (STAGES == 2) begin : g_two_stage
    logic              s0_valid_q, s0_valid_d;
    logic [ADDR_W-1:0] s0_addr_q, s0_addr_d;
    logic              s0_en_q, s0_en_d;

    always_comb begin
      s0_valid_d = s0_valid_q;
      s0_addr_d  = s0_addr_q;
      s0_en_d    = s0_en_q;
      if (flush) begin
        s0_valid_d = 1'b0;
      end else if (!stall) begin
        s0_valid_d = 1'b1;
        s0_addr_d  = in;
        s0_en_d    = enable;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s0_valid_q <= 1'b0;
        s0_addr_q  <= '0;
        s0_en_q    <= 1'b0;
      end else begin
        s0_valid_q <= s0_valid_d;
        s0_addr_q  <= s0_addr_d;
        s0_en_q    <= s0_en_d;
      end
    end

    assign src_valid = s0_valid_q;
    assign src_addr  = s0_addr_q;
    assign src_en    = s0_en_q;
  end else if (STAGES == 1) begin : g_one_stage
    assign src_valid = 1'b1;
    assign src_addr  = in;
    assign src_en    = enable;
  end else begin : g_bad_stages
    $fatal(1, "decoder_pipe_wsel: STAGES must be 1 or 2");
  end

  // Final stage decodes on capture so out is a pure flop output.
  logic [N-1:0]      out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] addr_d;
  logic              top_hit;

  assign top_hit = (SUPPRESS_TOP != 0) && (src_addr == ADDR_W'(N - 1));

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    addr_d      = addr_q;
    if (flush) begin
      out_d       = '0;
      out_valid_d = 1'b0;
    end else if (!stall) begin
      out_valid_d = src_valid;
      addr_d      = src_addr;
      out_d       = '0;
      if (src_valid && src_en && !top_hit) begin
        out_d[src_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef DECODE_ONEHOT_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (($countones(out_q) > 1) || (!out_valid_q && (out_q != '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_decoder_pipe_wsel.sv
// tb/tb_decoder_pipe_wsel.sv - randomized self-checking bench for decoder_pipe_wsel.
module tb_decoder_pipe_wsel;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  sel;
  logic        en, st, fl;

  logic [31:0] o1, o2, o3;
  logic        v1, v2, v3;
  logic [4:0]  a1, a2, a3;
`ifdef DECODE_ONEHOT_CHK_EN
  logic        e1, e2, e3;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          v;
    int unsigned a;
    bit          e;
  } samp_t;

  // Accepted samples, newest first; a flush kills everything still in flight.
  samp_t hist[$];

  always #5 clk = ~clk;

  decoder_pipe_wsel #(.ADDR_W(5), .STAGES(1), .SUPPRESS_TOP(1)) u_s1 (
    .clk(clk), .reset_n(reset_n), .in(sel), .enable(en), .stall(st), .flush(fl),
    .out(o1), .out_valid(v1), .addr_q(a1)
`ifdef DECODE_ONEHOT_CHK_EN
    , .err(e1)
`endif
  );

  decoder_pipe_wsel #(.ADDR_W(5), .STAGES(2), .SUPPRESS_TOP(1)) u_s2 (
    .clk(clk), .reset_n(reset_n), .in(sel), .enable(en), .stall(st), .flush(fl),
    .out(o2), .out_valid(v2), .addr_q(a2)
`ifdef DECODE_ONEHOT_CHK_EN
    , .err(e2)
`endif
  );

  decoder_pipe_wsel #(.ADDR_W(5), .STAGES(1), .SUPPRESS_TOP(0)) u_ns (
    .clk(clk), .reset_n(reset_n), .in(sel), .enable(en), .stall(st), .flush(fl),
    .out(o3), .out_valid(v3), .addr_q(a3)
`ifdef DECODE_ONEHOT_CHK_EN
    , .err(e3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input int lat, input bit sup,
                          input logic [31:0] o, input logic v, input logic [4:0] a);
    samp_t       s;
    logic [63:0] eo;
    s  = '{v: 1'b0, a: 0, e: 1'b0};
    if (hist.size() >= lat) s = hist[lat-1];
    eo = 64'd0;
    if (s.v && s.e && !(sup && s.a == 31)) eo = 64'd1 << s.a;
    chk({nm, ".out"}, {32'd0, o}, eo);
    chk({nm, ".valid"}, {63'd0, v}, {63'd0, s.v});
    if (s.v) chk({nm, ".addr"}, {59'd0, a}, 64'(s.a));
  endtask

  task automatic tick();
    @(posedge clk);
    if (fl) begin
      foreach (hist[i]) hist[i].v = 1'b0;
      hist.push_front('{v: 1'b0, a: 0, e: 1'b0});
    end else if (!st) begin
      hist.push_front('{v: 1'b1, a: int'(sel), e: en});
    end
    while (hist.size() > 2) void'(hist.pop_back());
    #1;
    chk_inst("s1", 1, 1'b1, o1, v1, a1);
    chk_inst("s2", 2, 1'b1, o2, v2, a2);
    chk_inst("ns", 1, 1'b0, o3, v3, a3);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    hist.delete();
    chk("rst.out1", {32'd0, o1}, 64'd0);
    chk("rst.val1", {63'd0, v1}, 64'd0);
    chk("rst.addr1", {59'd0, a1}, 64'd0);
    chk("rst.out2", {32'd0, o2}, 64'd0);
    chk("rst.val2", {63'd0, v2}, 64'd0);
`ifdef DECODE_ONEHOT_CHK_EN
    chk("rst.err1", {63'd0, e1}, 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drive(input logic [4:0] s, input logic e, input logic stl, input logic f);
    sel = s; en = e; st = stl; fl = f;
  endtask

  initial begin
    reset_n = 1'b1;
    drive(5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(5'd12, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    do_reset();

    drive(5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("basic.out", {32'd0, o1}, 64'h0000_0008);
    chk("basic.valid", {63'd0, v1}, 64'd1);
    chk("basic.addr", {59'd0, a1}, 64'd3);

    drive(5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("lat.e2", {32'd0, o2}, 64'd1);
    drive(5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("lat.e3", {32'd0, o2}, 64'd2);
    drive(5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lat.e4", {32'd0, o2}, 64'd4);

    drive(5'd31, 1'b1, 1'b0, 1'b0);
    tick();
    chk("xzr.out", {32'd0, o1}, 64'd0);
    chk("xzr.valid", {63'd0, v1}, 64'd1);
    chk("xzr.addr", {59'd0, a1}, 64'd31);
    chk("nosup.out", {32'd0, o3}, 64'h8000_0000);

    drive(5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(5'($urandom_range(0, 31)), 1'b1, 1'b1, 1'b0);
      tick();
      chk("stall.out", {32'd0, o1}, 64'h80);
    end
    drive(5'd20, 1'b1, 1'b1, 1'b1);
    tick();
    chk("flush.out", {32'd0, o1}, 64'd0);
    chk("flush.valid", {63'd0, v1}, 64'd0);
    chk("flush.addr", {59'd0, a1}, 64'd7);

    drive(5'd9, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bubble.out", {32'd0, o1}, 64'd0);
    chk("bubble.valid", {63'd0, v1}, 64'd1);
    chk("bubble.addr", {59'd0, a1}, 64'd9);

    drive(5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    do_reset();

    for (int c = 0; c < 10000; c++) begin
      drive(5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      tick();
    end

`ifdef DECODE_ONEHOT_CHK_EN
    chk("chk.err1", {63'd0, e1}, 64'd0);
    chk("chk.err2", {63'd0, e2}, 64'd0);
    chk("chk.err3", {63'd0, e3}, 64'd0);
    drive(5'd0, 1'b0, 1'b1, 1'b0);
    force u_s1.out_q = 32'h0000_0003;
    @(posedge clk);
    #1;
    chk("force.err", {63'd0, e1}, 64'd1);
    release u_s1.out_q;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("sticky.err", {63'd0, e1}, 64'd1);
    chk("other.err", {63'd0, e2}, 64'd0);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
